// File: rtl/cordic_phase_sequencer.sv
// Phase-accumulated angle driver and result collector for a pipelined
// CORDIC rotator, with a credit-guarded result FIFO.
// Ports: i_clock, i_reset (async, high); i_start/i_stop burst control;
//   i_phase_init/i_phase_inc/i_burst_len/i_amp burst parameters;
//   o_x_drv/o_y_drv/o_angle_drv to rotator; i_cordic_x/i_cordic_y back;
//   o_res_x/o_res_y/o_res_valid/i_res_ready result FIFO head;
//   o_busy (RUN or DRAIN), o_done (one pulse when drained).
// Optional: define PHASE_DITHER_EN to add LFSR dither to o_angle_drv.
module cordic_phase_sequencer #(
  parameter int CORDIC_LAT  = 15,
  parameter int FIFO_DEPTH  = 16,
  parameter int DITHER_BITS = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [31:0] i_phase_init,
  input  logic [31:0] i_phase_inc,
  input  logic [15:0] i_burst_len,
  input  logic [15:0] i_amp,
  output logic [15:0] o_x_drv,
  output logic [15:0] o_y_drv,
  output logic [31:0] o_angle_drv,
  input  logic [15:0] i_cordic_x,
  input  logic [15:0] i_cordic_y,
  output logic [15:0] o_res_x,
  output logic [15:0] o_res_y,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic        o_busy,
  output logic        o_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(CORDIC_LAT + 2);

  if (DITHER_BITS < 1 || DITHER_BITS > 16) begin : g_chk
    $error("DITHER_BITS must be 1..16");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0] r_acc;
  logic [31:0] r_inc;
  logic [15:0] r_amp;
  logic [15:0] r_len;
  logic [15:0] r_cnt;
  logic [CORDIC_LAT-1:0] r_tag;
  logic        r_cap;
  logic [IW-1:0] r_inflight;
  logic [15:0] r_x_drv;
  logic [31:0] r_angle_drv;
  logic        r_done;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [15:0] r_mem_x [FIFO_DEPTH];
  logic [15:0] r_mem_y [FIFO_DEPTH];

  logic        w_issue;
  logic        w_latch;
  logic        w_done_nxt;
  logic        w_push;
  logic        w_pop;
  logic        w_credit;
  logic [15:0] w_cnt_nxt;
  logic [31:0] w_angle_nxt;

  // r_tag marks the rotator sample window; r_cap is the extra edge
  // at which the rotator output for that sample is actually valid.
  assign w_push = r_cap;
  assign w_pop  = o_res_valid & i_res_ready;

  // Occupancy after this edge must stay within the FIFO; a pop this
  // cycle frees a slot the issue may reuse.
  assign w_credit = (32'(r_inflight) + 32'(r_count) - 32'(w_pop))
                    < 32'(FIFO_DEPTH);

  assign w_cnt_nxt = r_cnt + 16'(w_issue);

`ifdef PHASE_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_lfsr <= 16'hACE1;
    end else if (w_issue) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign w_angle_nxt = r_acc +
    {{(32-DITHER_BITS){1'b0}}, r_lfsr[DITHER_BITS-1:0]};
`else
  assign w_angle_nxt = r_acc;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_latch     = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_latch     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_issue = w_credit;
        if (i_stop || (r_len != 16'd0 && w_cnt_nxt == r_len)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_inflight == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_inc       <= '0;
      r_amp       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_tag       <= '0;
      r_cap       <= 1'b0;
      r_inflight  <= '0;
      r_x_drv     <= '0;
      r_angle_drv <= '0;
      r_done      <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= w_done_nxt;
      r_tag      <= {r_tag[CORDIC_LAT-2:0], w_issue};
      r_cap      <= r_tag[CORDIC_LAT-1];
      r_inflight <= r_inflight + IW'(w_issue) - IW'(r_cap);
      if (w_latch) begin
        r_acc <= i_phase_init;
        r_inc <= i_phase_inc;
        r_amp <= i_amp;
        r_len <= i_burst_len;
        r_cnt <= '0;
      end else if (w_issue) begin
        r_angle_drv <= w_angle_nxt;
        r_x_drv     <= r_amp;
        r_acc       <= r_acc + r_inc;
        r_cnt       <= w_cnt_nxt;
      end
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem_x[r_wptr] <= i_cordic_x;
      r_mem_y[r_wptr] <= i_cordic_y;
    end
  end

  // Head is masked when empty so stale storage never shows.
  assign o_res_valid = (r_count != '0);
  assign o_res_x     = o_res_valid ? r_mem_x[r_rptr] : '0;
  assign o_res_y     = o_res_valid ? r_mem_y[r_rptr] : '0;
  assign o_x_drv     = r_x_drv;
  assign o_y_drv     = '0;
  assign o_angle_drv = r_angle_drv;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Bench for cordic_phase_sequencer with a behavioural rotator and a
// scoreboard of expected rotated results.
module tb_cordic_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop;
  logic [31:0] phase_init, phase_inc;
  logic [15:0] burst_len, amp;
  logic [15:0] x_drv, y_drv;
  logic [31:0] angle_drv;
  logic [15:0] cordic_x, cordic_y;
  logic [15:0] res_x, res_y;
  logic        res_valid, res_ready;
  logic        busy, done;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  cordic_phase_sequencer dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_stop      (stop),
    .i_phase_init(phase_init),
    .i_phase_inc (phase_inc),
    .i_burst_len (burst_len),
    .i_amp       (amp),
    .o_x_drv     (x_drv),
    .o_y_drv     (y_drv),
    .o_angle_drv (angle_drv),
    .i_cordic_x  (cordic_x),
    .i_cordic_y  (cordic_y),
    .o_res_x     (res_x),
    .o_res_y     (res_y),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_busy      (busy),
    .o_done      (done)
  );

  function automatic logic [15:0] rot(input logic [15:0] a,
                                      input logic [31:0] ang,
                                      input bit sin_sel);
    real th, v;
    int r;
    th = real'(ang) * 6.283185307179586 / 4294967296.0;
    v = real'($signed(a)) * 0.978 * (sin_sel ? $sin(th) : $cos(th));
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else r = -$rtoi(-v + 0.5);
    return 16'(r);
  endfunction

  // Rotator: 15-edge pipeline from drive ports to x/y outputs.
  logic [15:0] px [15];
  logic [31:0] pa [15];
  always @(posedge clk) begin
    px[0] <= x_drv;
    pa[0] <= angle_drv;
    for (int i = 1; i < 15; i++) begin
      px[i] <= px[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign cordic_x = rot(px[14], pa[14], 1'b0);
  assign cordic_y = rot(px[14], pa[14], 1'b1);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra", 32'(sb_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("res_x", {16'b0, res_x}, {16'b0, e[31:16]});
        chk("res_y", {16'b0, res_y}, {16'b0, e[15:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic [31:0] init, input logic [31:0] inc,
                            input logic [15:0] a, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] ang;
      ang = init + 32'(k) * inc;
      sb_q.push_back({rot(a, ang, 1'b0), rot(a, ang, 1'b1)});
    end
  endtask

  task automatic start_burst(input logic [31:0] init, input logic [31:0] inc,
                             input logic [15:0] a, input logic [15:0] len);
    phase_init = init;
    phase_inc  = inc;
    amp        = a;
    burst_len  = len;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic finish_burst(input string tag, input int d0);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_done_to"}, 32'(n < 3000), 32'd1);
    n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
    repeat (3) tick();
    chk({tag, "_dpulse"}, 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    phase_init = '0;
    phase_inc = '0;
    burst_len = '0;
    amp = '0;
    res_ready = 1'b1;
    #1;
    chk("rst_ctl", {29'b0, busy, done, res_valid}, 32'd0);
    chk("rst_drv", {x_drv, y_drv}, 32'd0);
    chk("rst_ang", angle_drv, 32'd0);
    chk("rst_res", {res_x, res_y}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 1: quadrant steps
    d0 = n_done;
    push_burst(32'h0, 32'h4000_0000, 16'd10000, 4);
    start_burst(32'h0, 32'h4000_0000, 16'd10000, 16'd4);
    finish_burst("t1", d0);

    // 2: accumulator wrap, checked directly on the drive port
    d0 = n_done;
    push_burst(32'hF000_0000, 32'h2000_0000, 16'd10000, 3);
    start_burst(32'hF000_0000, 32'h2000_0000, 16'd10000, 16'd3);
    tick();
    chk("t2_a0", angle_drv, 32'hF000_0000);
    chk("t2_xy", {x_drv, y_drv}, {16'd10000, 16'd0});
    tick();
    chk("t2_a1", angle_drv, 32'h1000_0000);
    tick();
    chk("t2_a2", angle_drv, 32'h3000_0000);
    finish_burst("t2", d0);

    // 3: full backpressure, credit caps issue at FIFO depth
    d0 = n_done;
    res_ready = 1'b0;
    push_burst(32'h0, 32'h0800_0000, 16'd8000, 32);
    start_burst(32'h0, 32'h0800_0000, 16'd8000, 16'd32);
    repeat (60) tick();
    chk("t3_ang", angle_drv, 32'h7800_0000);
    chk("t3_stat", {30'b0, busy, res_valid}, 32'd3);
    res_ready = 1'b1;
    finish_burst("t3", d0);

    // 4: continuous mode ended by stop on the 7th issue
    d0 = n_done;
    push_burst(32'h1234_5678, 32'h0300_0000, 16'hE4A8, 7);
    start_burst(32'h1234_5678, 32'h0300_0000, 16'hE4A8, 16'd0);
    repeat (6) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    finish_burst("t4", d0);
    repeat (30) tick();
    chk("t4_idle", {30'b0, busy, res_valid}, 32'd0);

    // 5: reset during a burst, then a clean short burst
    push_burst(32'h0, 32'h0100_0000, 16'd12000, 20);
    start_burst(32'h0, 32'h0100_0000, 16'd12000, 16'd20);
    repeat (5) tick();
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk("t5_ctl", {29'b0, busy, done, res_valid}, 32'd0);
    chk("t5_drv", {x_drv, y_drv}, 32'd0);
    chk("t5_ang", angle_drv, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    d0 = n_done;
    push_burst(32'h4000_0000, 32'h8000_0000, 16'd9000, 2);
    start_burst(32'h4000_0000, 32'h8000_0000, 16'd9000, 16'd2);
    finish_burst("t5", d0);
    repeat (40) tick();
    chk("t5_stale", {31'b0, res_valid}, 32'd0);

    // 6: start during RUN must not disturb the burst
    d0 = n_done;
    push_burst(32'h1000_0000, 32'h0400_0000, 16'd5000, 8);
    start_burst(32'h1000_0000, 32'h0400_0000, 16'd5000, 16'd8);
    repeat (2) tick();
    phase_init = 32'h0;
    phase_inc  = 32'h4000_0000;
    amp        = 16'd20000;
    burst_len  = 16'd1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    finish_burst("t6", d0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
